// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
`default_nettype none

package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;

  // A single requester still needs a one-bit ID field.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_share_sched_rr_pick.sv
// Combinational round-robin selector: first requester after last_grant, with wrap.
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any_req
);

  logic found;
  int   j;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    j       = 0;
    // Scan last_grant+1 .. last_grant+NREQ so the previous winner ranks last.
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_grant) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_share_sched.sv
// Time-shares one registered nibble adder among NREQ requesters, round-robin.
`default_nettype none

module adder_share_sched
  import adder_share_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int W    = DEF_W,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W:0]      rsp_sum,
  output logic            busy
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            pick_any;
  logic [W-1:0]    op_a, op_b;
  logic [IDW-1:0]  op_id;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_req   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so no accept strobe leaks out while reset is held.
        if (pick_any && rst_n) begin
          req_ready = pick_grant;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        op_a       <= a_arr[pick_idx];
        op_b       <= b_arr[pick_idx];
        op_id      <= pick_idx;
        last_grant <= pick_idx;
      end
      if (state == EXEC) begin
        rsp_sum <= {1'b0, op_a} + {1'b0, op_b};
        rsp_id  <= op_id;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_share_sched.sv
// Scoreboard bench for adder_share_sched: grant order, latency, backpressure, reset.
`default_nettype none

module tb_adder_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;

  typedef struct {
    logic [1:0] id;
    logic [W:0] sum;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  adder_share_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic exp_t mk(input int id, input int a, input int b);
    exp_t x;
    x.id  = 2'(id);
    x.sum = 5'(a + b);
    return x;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    #3;
    tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rr=%b rv=%b id=%0d sum=%0d busy=%b, want all 0",
               req_ready, rsp_valid, rsp_id, rsp_sum, busy);
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    set_op(0, 4'd7, 4'd5);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL basic_ready: got %b want 0001", req_ready);
    end
    q.push_back(mk(0, 7, 5));
    tick;
    req_valid = '0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_exec: got rv=%b busy=%b want rv=0 busy=1", rsp_valid, busy);
    end
    tick;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || q.size() == 0) begin
      fails++;
      $display("FAIL basic_latency: got rv=%b at cycle 2 want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL basic_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_drop: got rv=%b busy=%b at cycle 3 want 0 0", rsp_valid, busy);
    end
    tick;
  endtask

  task automatic test_carry;
    set_op(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL carry_ready: got %b want 0100", req_ready);
    end
    q.push_back(mk(2, 15, 15));
    tick;
    req_valid = '0;
    tick;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || q.size() == 0) begin
      fails++;
      $display("FAIL carry_latency: got rv=%b want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL carry_rsp: got id=%0d sum=%b want id=%0d sum=%b", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
  endtask

  task automatic test_round_robin;
    int grants = 0;
    int last_c = 0;
    int got = 0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(3*i + 2), 4'(9 - i));
    req_valid = 4'b1111;
    for (int c = 0; c < 40 && grants < 5; c++) begin
      #1;
      if (req_ready !== '0) begin
        tests++;
        if (req_ready !== 4'(1 << (grants % NREQ)) || (grants > 0 && c - last_c != 3)) begin
          fails++;
          $display("FAIL rr_grant%0d: got %b after %0d cycles want %b after 3",
                   grants, req_ready, c - last_c, 4'(1 << (grants % NREQ)));
        end
        q.push_back(mk(grants % NREQ, 3*(grants % NREQ) + 2, 9 - (grants % NREQ)));
        grants++;
        last_c = c;
      end
      if (rsp_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rr_rsp: got unexpected id=%0d sum=%0d want none", rsp_id, rsp_sum);
        end else begin
          e = q.pop_front();
          got++;
          if (rsp_id !== e.id || rsp_sum !== e.sum) begin
            fails++;
            $display("FAIL rr_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
          end
        end
      end
      tick;
    end
    req_valid = '0;
    tests++;
    if (grants != 5) begin
      fails++;
      $display("FAIL rr_count: got %0d grants want 5", grants);
    end
    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        e = q.pop_front();
        got++;
        tests++;
        if (rsp_id !== e.id || rsp_sum !== e.sum) begin
          fails++;
          $display("FAIL rr_last_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
        end
      end
      tick;
    end
    tests++;
    if (got != 5) begin
      fails++;
      $display("FAIL rr_rsp_count: got %0d responses want 5", got);
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic ok;
    set_op(1, 4'd6, 4'd8);
    set_op(2, 4'd1, 4'd2);
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL bp_ready: got %b want 0010", req_ready);
    end
    q.push_back(mk(1, 6, 8));
    tick;
    tick;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 5'd14 || req_ready !== '0) begin
        ok = 1'b0;
        $display("FAIL bp_hold%0d: got rv=%b id=%0d sum=%0d rr=%b want 1 1 14 0000",
                 c, rsp_valid, rsp_id, rsp_sum, req_ready);
      end
      tick;
    end
    tests++;
    if (!ok) fails++;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (q.size() == 0 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_rsp: got rv=%b want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL bp_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL bp_next_grant: got %b want 0100", req_ready);
    end
    q.push_back(mk(2, 1, 2));
    tick;
    req_valid = '0;
    tick;
    #1;
    tests++;
    if (q.size() == 0 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_rsp2: got rv=%b want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL bp_rsp2: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
  endtask

  task automatic test_operand_change;
    set_op(1, 4'd3, 4'd4);
    req_valid = 4'b0010;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL opchg_ready: got %b want 0010", req_ready);
    end
    q.push_back(mk(1, 3, 4));
    tick;
    set_op(1, 4'd9, 4'd9);
    req_valid = '0;
    tick;
    #1;
    tests++;
    if (q.size() == 0 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL opchg_rsp: got rv=%b want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL opchg_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
  endtask

  task automatic test_async_reset;
    logic ok;
    set_op(3, 4'd5, 4'd5);
    req_valid = 4'b1000;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL areset_grant: got %b want 1000", req_ready);
    end
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum, busy} !== '0) begin
      fails++;
      $display("FAIL areset_immediate: got rr=%b rv=%b id=%0d sum=%0d busy=%b want all 0",
               req_ready, rsp_valid, rsp_id, rsp_sum, busy);
    end
    req_valid = '0;
    tick;
    tick;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL areset_quiet%0d: got rv=%b busy=%b want 0 0", c, rsp_valid, busy);
      end
      tick;
    end
    tests++;
    if (!ok) fails++;
    set_op(0, 4'd4, 4'd9);
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL areset_first_grant: got %b want 0001", req_ready);
    end
    q.push_back(mk(0, 4, 9));
    tick;
    req_valid = '0;
    tick;
    #1;
    tests++;
    if (q.size() == 0 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL areset_rsp: got rv=%b want 1", rsp_valid);
    end else begin
      e = q.pop_front();
      if (rsp_id !== e.id || rsp_sum !== e.sum) begin
        fails++;
        $display("FAIL areset_rsp: got id=%0d sum=%0d want id=%0d sum=%0d", rsp_id, rsp_sum, e.id, e.sum);
      end
    end
    tick;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_round_robin;
    test_backpressure;
    test_operand_change;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
